// File: rtl/clefia_pkg.sv
// clefia_pkg: shared constants, state encoding and key-order helpers for
// the CLEFIA key sequencing blocks.
package clefia_pkg;

  localparam int NUM_RK_128 = 36;
  localparam int NUM_RK_192 = 44;
  localparam int NUM_RK_256 = 52;
  localparam int RK_W       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rk_state_e;

  // Whitening words WK0..WK3 live directly after the round keys.
  function automatic int wk_base(input int num_rk);
    return num_rk;
  endfunction

  // Storage address of the idx-th key consumed in a block. Decryption
  // walks the RK pairs from the top down but keeps word order in a pair.
  function automatic int rk_order(input int idx, input logic dec, input int num_rk);
    int pairBase;
    pairBase = idx - (idx % 2);
    if (dec) begin
      return (num_rk - 2) - pairBase + (idx % 2);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rk_addr_gen.sv
// rk_addr_gen: key index counter. Presents the storage address of the key
// that will be visible after the coming clock edge, so the top level can
// register round_key straight from storage.
module rk_addr_gen #(
  parameter int NUM_RK = 36,
  parameter int AW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          decrypt,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);
  import clefia_pkg::*;

  logic [AW-1:0] r_idx;
  logic          r_dec;
  logic [AW-1:0] w_idx_nxt;
  logic          w_dec_nxt;

  // Next index/direction: load restarts at key 0, step advances until the last key.
  always_comb begin
    w_idx_nxt = r_idx;
    w_dec_nxt = r_dec;
    if (load) begin
      w_idx_nxt = '0;
      w_dec_nxt = decrypt;
    end else if (step && !last) begin
      w_idx_nxt = r_idx + 1'b1;
    end
  end

  assign addr = AW'(rk_order(int'(w_idx_nxt), w_dec_nxt, NUM_RK));
  assign last = (r_idx == AW'(NUM_RK - 1));

  // Index and direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_dec <= 1'b0;
    end else begin
      r_idx <= w_idx_nxt;
      r_dec <= w_dec_nxt;
    end
  end

endmodule

// File: rtl/rk_sequencer.sv
// rk_sequencer: stores expanded CLEFIA round keys and whitening keys and
// feeds them to data_processing one word per F step, in encrypt or decrypt
// order. Optional macro KEY_ZEROIZE_EN enables the key_zero request.
module rk_sequencer #(
  parameter int NUM_RK = 36,
  parameter int RK_W   = 32,
  parameter int AW     = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_wr_en,
  input  logic [AW-1:0]   key_wr_addr,
  input  logic [RK_W-1:0] key_wr_data,
  input  logic            key_commit,
  input  logic            key_zero,
  input  logic            start,
  input  logic            decrypt,
  input  logic            rk_step,
  output logic [RK_W-1:0] round_key,
  output logic            rk_valid,
  output logic [RK_W-1:0] WK0,
  output logic [RK_W-1:0] WK1,
  output logic            wk_final,
  output logic            keys_ok,
  output logic            busy,
  output logic            done
);
  import clefia_pkg::*;

  localparam int NWORDS = NUM_RK + 4;
  localparam int WKB    = wk_base(NUM_RK);

  logic [RK_W-1:0] r_mem [NWORDS];
  rk_state_e       r_state;
  logic [RK_W-1:0] r_round_key;
  logic [RK_W-1:0] r_wk0;
  logic [RK_W-1:0] r_wk1;
  logic            r_wk_final;
  logic            r_keys_ok;
  logic            r_dec;

  logic            w_zero;
  logic            w_start_acc;
  logic            w_step;
  logic            w_wr_ok;
  logic            w_commit;
  logic [AW-1:0]   w_addr;
  logic            w_last;

`ifdef KEY_ZEROIZE_EN
  assign w_zero = key_zero;
`else
  logic w_unused_key_zero;
  assign w_unused_key_zero = key_zero;
  assign w_zero = 1'b0;
`endif

  assign w_start_acc = start && r_keys_ok && (r_state == IDLE) && !w_zero;
  assign w_step      = rk_step && (r_state == RUN) && !w_zero;
  assign w_wr_ok     = key_wr_en && (r_state != RUN) && !w_zero &&
                       (int'(key_wr_addr) < NWORDS);
  assign w_commit    = key_commit && (r_state != RUN) && !w_zero;

  rk_addr_gen #(
    .NUM_RK (NUM_RK),
    .AW     (AW)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (w_start_acc),
    .decrypt (decrypt),
    .step    (w_step),
    .addr    (w_addr),
    .last    (w_last)
  );

  // Key storage: cleared by reset or zeroize, written only outside a block.
  always_ff @(posedge clk) begin
    if (rst || w_zero) begin
      for (int i = 0; i < NWORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[key_wr_addr] <= key_wr_data;
    end
  end

  // keys_ok: any accepted write invalidates the set until it is committed again.
  always_ff @(posedge clk) begin
    if (rst || w_zero) begin
      r_keys_ok <= 1'b0;
    end else if (w_wr_ok) begin
      r_keys_ok <= 1'b0;
    end else if (w_commit) begin
      r_keys_ok <= 1'b1;
    end
  end

  // Block FSM with registered key and whitening-pair outputs.
  always_ff @(posedge clk) begin
    if (rst || w_zero) begin
      r_state     <= IDLE;
      r_round_key <= '0;
      r_wk0       <= '0;
      r_wk1       <= '0;
      r_wk_final  <= 1'b0;
      r_dec       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_acc) begin
            r_state     <= RUN;
            r_dec       <= decrypt;
            r_round_key <= r_mem[w_addr];
            r_wk_final  <= 1'b0;
            if (decrypt) begin
              r_wk0 <= r_mem[WKB + 2];
              r_wk1 <= r_mem[WKB + 3];
            end else begin
              r_wk0 <= r_mem[WKB + 0];
              r_wk1 <= r_mem[WKB + 1];
            end
          end
        end
        RUN: begin
          if (w_step) begin
            if (w_last) begin
              r_state    <= DONE;
              r_wk_final <= 1'b1;
              if (r_dec) begin
                r_wk0 <= r_mem[WKB + 0];
                r_wk1 <= r_mem[WKB + 1];
              end else begin
                r_wk0 <= r_mem[WKB + 2];
                r_wk1 <= r_mem[WKB + 3];
              end
            end else begin
              r_round_key <= r_mem[w_addr];
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign round_key = r_round_key;
  assign WK0       = r_wk0;
  assign WK1       = r_wk1;
  assign wk_final  = r_wk_final;
  assign keys_ok   = r_keys_ok;
  assign busy      = (r_state == RUN);
  assign rk_valid  = (r_state == RUN);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_rk_sequencer.sv
// tb_rk_sequencer: scoreboard bench for rk_sequencer. The driver pushes the
// expected output for every cycle in which the DUT should present a key or a
// done pulse; the monitor pops and compares whenever rk_valid or done is high.
// Honors KEY_ZEROIZE_EN the same way as the design.
module tb_rk_sequencer;

  localparam int N  = 36;
  localparam int RW = 32;
  localparam int AW = 6;
  localparam int NW = N + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_wr_en;
  logic [AW-1:0] key_wr_addr;
  logic [RW-1:0] key_wr_data;
  logic          key_commit;
  logic          key_zero;
  logic          start;
  logic          decrypt;
  logic          rk_step;
  logic [RW-1:0] round_key;
  logic          rk_valid;
  logic [RW-1:0] WK0;
  logic [RW-1:0] WK1;
  logic          wk_final;
  logic          keys_ok;
  logic          busy;
  logic          done;

  rk_sequencer #(.NUM_RK(N), .RK_W(RW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_wr_en   (key_wr_en),
    .key_wr_addr (key_wr_addr),
    .key_wr_data (key_wr_data),
    .key_commit  (key_commit),
    .key_zero    (key_zero),
    .start       (start),
    .decrypt     (decrypt),
    .rk_step     (rk_step),
    .round_key   (round_key),
    .rk_valid    (rk_valid),
    .WK0         (WK0),
    .WK1         (WK1),
    .wk_final    (wk_final),
    .keys_ok     (keys_ok),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isDone;
    logic [31:0] key;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        wf;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] model [NW];
  logic        expKeysOk;
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation is consumed for each cycle showing a key or done.
  always @(negedge clk) begin
    exp_t e;
    if (rk_valid || done) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output actual rk_valid=%0b done=%0b expected none", rk_valid, done);
      end else begin
        e = expQ.pop_front();
        if (e.isDone) begin
          checkOutput("done_pulse", 32'(done), 32'd1);
          checkOutput("done_rk_valid", 32'(rk_valid), 32'd0);
          checkOutput("done_busy", 32'(busy), 32'd0);
        end else begin
          checkOutput("round_key", round_key, e.key);
          checkOutput("run_busy", 32'(busy), 32'd1);
          checkOutput("run_done", 32'(done), 32'd0);
        end
        checkOutput("wk0", WK0, e.w0);
        checkOutput("wk1", WK1, e.w1);
        checkOutput("wk_final", 32'(wk_final), 32'(e.wf));
      end
    end
  end

  task automatic pushKey(input int k, input logic dec);
    exp_t e;
    e.isDone = 1'b0;
    e.key    = dec ? model[(N - 1 - k) ^ 1] : model[k];
    e.w0     = dec ? model[N + 2] : model[N];
    e.w1     = dec ? model[N + 3] : model[N + 1];
    e.wf     = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic pushDone(input logic dec);
    exp_t e;
    e.isDone = 1'b1;
    e.key    = '0;
    e.w0     = dec ? model[N] : model[N + 2];
    e.w1     = dec ? model[N + 1] : model[N + 3];
    e.wf     = 1'b1;
    expQ.push_back(e);
  endtask

  task automatic drainCheck(input string name);
    checkOutput(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  task automatic clearModel();
    for (int i = 0; i < NW; i++) model[i] = '0;
    expKeysOk = 1'b0;
  endtask

  task automatic writeWord(input int addr, input logic [31:0] data);
    key_wr_en   = 1'b1;
    key_wr_addr = AW'(addr);
    key_wr_data = data;
    tick();
    key_wr_en = 1'b0;
    if (addr < NW) begin
      model[addr] = data;
      expKeysOk   = 1'b0;
    end
  endtask

  task automatic commitKeys();
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
    expKeysOk  = 1'b1;
  endtask

  task automatic loadKeys();
    for (int i = 0; i < N; i++) writeWord(i, 32'h1000_0000 + 32'(i));
    for (int j = 0; j < 4; j++) writeWord(N + j, 32'hA0 + 32'(j));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_round_key"}, round_key, 32'd0);
    checkOutput({tag, "_rk_valid"}, 32'(rk_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_wk0"}, WK0, 32'd0);
    checkOutput({tag, "_wk1"}, WK1, 32'd0);
    checkOutput({tag, "_wk_final"}, 32'(wk_final), 32'd0);
    checkOutput({tag, "_keys_ok"}, 32'(keys_ok), 32'd0);
  endtask

  // One block: gapMode 0 = back-to-back steps, 1 = 0..5 idle cycles with a
  // disturbance at step 5, 2 = sparse single gaps. abortAt/zeroAt >= 0
  // interrupt the block with rst/key_zero before that key is stepped.
  task automatic applyStimulus(input logic dec, input int gapMode, input int abortAt, input int zeroAt);
    int gaps;
    start   = 1'b1;
    decrypt = dec;
    tick();
    start   = 1'b0;
    decrypt = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == abortAt) begin
        pushKey(k, dec);
        rst = 1'b1;
        tick();
        checkAllZero("mid_rst");
        rst = 1'b0;
        clearModel();
        tick();
        tick();
        drainCheck("rst_drain");
        return;
      end
      if (k == zeroAt) begin
        pushKey(k, dec);
        key_zero = 1'b1;
        tick();
        key_zero = 1'b0;
`ifdef KEY_ZEROIZE_EN
        checkAllZero("zeroize");
        clearModel();
        tick();
        tick();
        drainCheck("zero_drain");
        return;
`endif
      end
      gaps = (gapMode == 1) ? (k % 6) : ((gapMode == 2) ? ((k % 3 == 1) ? 1 : 0) : 0);
      for (int g = 0; g < gaps; g++) begin
        pushKey(k, dec);
        tick();
      end
      pushKey(k, dec);
      rk_step = 1'b1;
      if (gapMode == 1 && k == 5) begin
        key_wr_en   = 1'b1;
        key_wr_addr = '0;
        key_wr_data = 32'hDEAD_BEEF;
        key_commit  = 1'b1;
        start       = 1'b1;
        decrypt     = ~dec;
      end
      tick();
      rk_step    = 1'b0;
      key_wr_en  = 1'b0;
      key_commit = 1'b0;
      start      = 1'b0;
      decrypt    = 1'b0;
    end
    pushDone(dec);
    tick();
    tick();
    drainCheck("run_drain");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
    key_commit = 1'b0; key_zero = 1'b0; start = 1'b0; decrypt = 1'b0; rk_step = 1'b0;
    clearModel();
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    $display("[TB] start without committed keys");
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_no_keys_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("start_no_keys_busy_later", 32'(busy), 32'd0);
    drainCheck("no_keys_drain");

    $display("[TB] load, commit, out-of-range write");
    loadKeys();
    checkOutput("keys_ok_before_commit", 32'(keys_ok), 32'd0);
    commitKeys();
    checkOutput("keys_ok_after_commit", 32'(keys_ok), 32'd1);
    writeWord(63, 32'h5555_5555);
    checkOutput("keys_ok_after_addr63", 32'(keys_ok), 32'd1);

    $display("[TB] encrypt with gaps, write/commit/start during run");
    applyStimulus(1'b0, 1, -1, -1);
    checkOutput("keys_ok_after_run_write", 32'(keys_ok), 32'(expKeysOk));
    checkOutput("idle_hold_wk0", WK0, 32'hA2);
    checkOutput("idle_hold_wk1", WK1, 32'hA3);
    checkOutput("idle_hold_wk_final", 32'(wk_final), 32'd1);

    $display("[TB] decrypt");
    applyStimulus(1'b1, 2, -1, -1);
    checkOutput("dec_hold_wk0", WK0, 32'hA0);
    checkOutput("dec_hold_wk1", WK1, 32'hA1);

    $display("[TB] reset after step 10");
    applyStimulus(1'b0, 0, 10, -1);
    checkOutput("after_rst_keys_ok", 32'(keys_ok), 32'd0);

    $display("[TB] reload and full run");
    loadKeys();
    commitKeys();
    applyStimulus(1'b0, 0, -1, -1);

    $display("[TB] key_zero at step 5");
    applyStimulus(1'b0, 0, -1, 5);
    checkOutput("after_zero_keys_ok", 32'(keys_ok), 32'(expKeysOk));
    commitKeys();
    applyStimulus(1'b1, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
